// File: rtl/decode_pkg.sv
// core: shared decode types, RV32I opcode constants and the instruction decoder.
//   id_t     : {pc, ir} beat from fetch
//   ex_t     : decoded operation handed to execute
//   alu_op_t : ALU operation selector
//   dec()    : control/immediate decode of one id_t (operand values left 0)
package core;
    localparam int NREGS_DEF = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        logic        load;
        logic        store;
        logic        branch;
        logic        jump;
        logic        illegal;
    } ex_t;

    // rs2 is a real operand only for R, S and B formats
    function automatic logic uses_rs2(logic [31:0] ir);
        return ir[6:0] inside {OP_REG, OP_STORE, OP_BRANCH};
    endfunction

    function automatic alu_op_t alu_f3(logic [2:0] f3, logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic ex_t dec(id_t id);
        ex_t e;
        logic [31:0] ir;
        ir = id.ir;
        e = '0;
        e.pc = id.pc;
        e.rd = ir[11:7];
        e.funct3 = ir[14:12];
        case (ir[6:0])
            OP_LUI:    begin e.imm = {ir[31:12], 12'b0}; e.alu_op = ALU_PASS; end
            OP_AUIPC:  e.imm = {ir[31:12], 12'b0};
            OP_JAL:    begin e.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}; e.jump = 1'b1; end
            OP_JALR:   begin e.imm = {{20{ir[31]}}, ir[31:20]}; e.jump = 1'b1; end
            OP_BRANCH: begin
                e.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                e.branch = 1'b1;
                e.alu_op = ALU_SUB;
                e.rd = '0;
            end
            OP_LOAD:   begin e.imm = {{20{ir[31]}}, ir[31:20]}; e.load = 1'b1; end
            OP_STORE:  begin e.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]}; e.store = 1'b1; e.rd = '0; end
            // ir[30] is immediate data for OP-IMM except on the shift-right encoding
            OP_IMM:    begin e.imm = {{20{ir[31]}}, ir[31:20]}; e.alu_op = alu_f3(ir[14:12], ir[14:12] == 3'b101 && ir[30]); end
            OP_REG:    e.alu_op = alu_f3(ir[14:12], ir[30]);
            OP_FENCE, OP_SYSTEM: e.imm = {{20{ir[31]}}, ir[31:20]};
            default:   begin e.illegal = 1'b1; e.rd = '0; e.funct3 = '0; end
        endcase
        return e;
    endfunction
endpackage

// File: rtl/decode_if.sv
// axis: valid/ready stream carrying aclk/aresetn alongside the beat.
//   aclk, aresetn : shared clock and synchronous active-low reset
//   tvalid/tready : handshake, tdata : W-bit payload
//   master drives tvalid/tdata, slave drives tready
interface axis #(parameter int W = 32) (input logic aclk, input logic aresetn);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    modport master (input aclk, aresetn, tready, output tvalid, tdata);
    modport slave  (input aclk, aresetn, tvalid, tdata, output tready);
endinterface

// File: rtl/decode_regfile.sv
// regfile: NREGS x 32 register file, x0 reads as zero and ignores writes.
//   clk_i            : clock
//   we_i/wa_i/wd_i   : synchronous write port
//   ra1_i/rd1_o      : asynchronous read port 1
//   ra2_i/rd2_o      : asynchronous read port 2
module regfile import core::*; #(
    parameter int NREGS = NREGS_DEF
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] mem_q [NREGS];

    always_ff @(posedge clk_i)
        if (we_i && |wa_i) mem_q[wa_i] <= wd_i;

    assign rd1_o = |ra1_i ? mem_q[ra1_i] : '0;
    assign rd2_o = |ra2_i ? mem_q[ra2_i] : '0;
endmodule

// File: rtl/decode.sv
// decode: single register stage turning fetch beats into execute operations.
//   source  : axis slave, id_t beats from fetch (also supplies aclk/aresetn)
//   sink    : axis master, ex_t beats to execute
//   branch  : execute redirect, kills the stage
//   ex_load, ex_rd        : load-use hazard detection against execute
//   wb_en, wb_rd, wb_data : register file write port
//   bubble  : stall request to fetch
// Build option DECODE_BYPASS_EN: forward same-cycle writeback data instead of
// stalling one cycle on a writeback/read collision.
module decode import core::*; #(
    parameter int NREGS = NREGS_DEF
) (
    axis.slave          source,
    axis.master         sink,
    input  logic        branch,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        bubble
);
    id_t         id;
    ex_t         ex_d, data_q;
    logic        valid_q;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2;
    logic        r2, ld_hz, wb_hz, hazard, src_fire, fwd1, fwd2;

    assign id  = source.tdata;
    assign rs1 = id.ir[19:15];
    assign rs2 = id.ir[24:20];
    assign r2  = uses_rs2(id.ir);

    regfile #(.NREGS(NREGS)) u_rf (
        .clk_i (source.aclk),
        .we_i  (wb_en),
        .wa_i  (wb_rd),
        .wd_i  (wb_data),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign ld_hz = ex_load && |ex_rd && (ex_rd == rs1 || (r2 && ex_rd == rs2));

`ifdef DECODE_BYPASS_EN
    assign fwd1  = wb_en && |wb_rd && wb_rd == rs1;
    assign fwd2  = wb_en && |wb_rd && wb_rd == rs2;
    assign wb_hz = 1'b0;
`else
    // register file is read-before-write: a colliding write costs one stall
    assign fwd1  = 1'b0;
    assign fwd2  = 1'b0;
    assign wb_hz = wb_en && |wb_rd && (wb_rd == rs1 || (r2 && wb_rd == rs2));
`endif

    always_comb begin
        ex_d = dec(id);
        ex_d.rs1_val = fwd1 ? wb_data : rd1;
        ex_d.rs2_val = fwd2 ? wb_data : rd2;
    end

    assign hazard        = source.tvalid && (ld_hz || wb_hz);
    assign bubble        = source.aresetn && hazard;
    assign source.tready = source.aresetn && sink.tready && !hazard && !branch;
    assign src_fire      = source.tvalid && source.tready;

    // branch outranks everything; an idle ready cycle (incl. a hazard) drains to a nop
    always_ff @(posedge source.aclk) begin
        if (!source.aresetn) valid_q <= 1'b0;
        else if (branch)     valid_q <= 1'b0;
        else if (src_fire)   valid_q <= 1'b1;
        else if (sink.tready) valid_q <= 1'b0;
        if (src_fire) data_q <= ex_d;
    end

    assign sink.tvalid = valid_q;
    assign sink.tdata  = data_q;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed self-checking bench for decode.
module tb_decode;
    import core::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis #(.W($bits(id_t))) src (.aclk(clk), .aresetn(rstn));
    axis #(.W($bits(ex_t))) snk (.aclk(clk), .aresetn(rstn));

    logic        branch, ex_load, wb_en, bubble;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] wb_data;
    ex_t         o;
    int          n_chk = 0;
    int          n_fail = 0;

    decode dut (
        .source  (src),
        .sink    (snk),
        .branch  (branch),
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .bubble  (bubble)
    );

    assign o = snk.tdata;

    logic [31:0] t_ir  [5];
    logic [31:0] t_imm [5];
    logic [4:0]  t_fl  [5];
    logic [3:0]  t_alu [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir);
        src.tvalid = 1'b1;
        src.tdata  = {pc, ir};
    endtask

    initial begin
        t_ir[0] = 32'hFE210EE3; t_imm[0] = 32'hFFFFFFFC; t_fl[0] = 5'b00100; t_alu[0] = 4'd1;
        t_ir[1] = 32'h008000EF; t_imm[1] = 32'h00000008; t_fl[1] = 5'b00010; t_alu[1] = 4'd0;
        t_ir[2] = 32'h123452B7; t_imm[2] = 32'h12345000; t_fl[2] = 5'b00000; t_alu[2] = 4'd10;
        t_ir[3] = 32'h403100B3; t_imm[3] = 32'h00000000; t_fl[3] = 5'b00000; t_alu[3] = 4'd1;
        t_ir[4] = 32'h40315093; t_imm[4] = 32'h00000403; t_fl[4] = 5'b00000; t_alu[4] = 4'd7;

        branch = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        ex_load = 1'b1; ex_rd = 5'd5; snk.tready = 1'b1;
        send(32'h0, 32'h00028333);
        tick;
        tick;
        chk("rst_sink_valid", 32'(snk.tvalid), 0);
        chk("rst_src_ready", 32'(src.tready), 0);
        chk("rst_bubble", 32'(bubble), 0);
        rstn = 1'b1; ex_load = 1'b0; src.tvalid = 1'b0;

        // addi x1,x0,5
        send(32'h0, 32'h00500093);
        #1 chk("addi_src_ready", 32'(src.tready), 1);
        tick;
        src.tvalid = 1'b0;
        #1;
        chk("addi_valid", 32'(snk.tvalid), 1);
        chk("addi_rd", 32'(o.rd), 1);
        chk("addi_imm", o.imm, 32'd5);
        chk("addi_rs1", o.rs1_val, 0);
        chk("addi_pc", o.pc, 0);

        // write x2 then add x3,x2,x2
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234;
        tick;
        wb_en = 1'b0;
        send(32'h4, 32'h002101B3);
        tick;
        src.tvalid = 1'b0;
        #1;
        chk("add_valid", 32'(snk.tvalid), 1);
        chk("add_rs1", o.rs1_val, 32'h1234);
        chk("add_rs2", o.rs2_val, 32'h1234);
        chk("add_rd", 32'(o.rd), 3);

        // same-cycle writeback of the source register
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h5678;
        send(32'h8, 32'h002101B3);
        #1;
`ifdef DECODE_BYPASS_EN
        chk("wb_bubble", 32'(bubble), 0);
        tick;
        wb_en = 1'b0; src.tvalid = 1'b0;
        #1;
`else
        chk("wb_bubble", 32'(bubble), 1);
        chk("wb_src_ready", 32'(src.tready), 0);
        tick;
        wb_en = 1'b0;
        #1;
        chk("wb_nop", 32'(snk.tvalid), 0);
        chk("wb_bubble_clear", 32'(bubble), 0);
        tick;
        src.tvalid = 1'b0;
        #1;
`endif
        chk("wb_valid", 32'(snk.tvalid), 1);
        chk("wb_rs1", o.rs1_val, 32'h5678);
        chk("wb_pc", o.pc, 32'h8);

        // load-use: add x6,x5,x0 behind a load to x5
        ex_load = 1'b1; ex_rd = 5'd5;
        send(32'hC, 32'h00028333);
        #1;
        chk("lu_bubble", 32'(bubble), 1);
        chk("lu_src_ready", 32'(src.tready), 0);
        tick;
        ex_load = 1'b0;
        #1;
        chk("lu_nop", 32'(snk.tvalid), 0);
        chk("lu_bubble_clear", 32'(bubble), 0);
        tick;
        #1;
        chk("lu_valid", 32'(snk.tvalid), 1);
        chk("lu_rd", 32'(o.rd), 6);

        // backpressure for three cycles with lw x7,4(x1) waiting
        snk.tready = 1'b0;
        send(32'h10, 32'h0040A383);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_src_ready", 32'(src.tready), 0);
            chk("bp_valid", 32'(snk.tvalid), 1);
            chk("bp_pc", o.pc, 32'hC);
            chk("bp_rd", 32'(o.rd), 6);
            tick;
        end
        snk.tready = 1'b1;
        tick;
        src.tvalid = 1'b0;
        #1;
        chk("lw_valid", 32'(snk.tvalid), 1);
        chk("lw_load", 32'(o.load), 1);
        chk("lw_imm", o.imm, 32'd4);
        chk("lw_f3", 32'(o.funct3), 2);
        chk("lw_rd", 32'(o.rd), 7);

        // branch kill with sw x2,8(x0) presented
        branch = 1'b1;
        send(32'h14, 32'h00202423);
        #1 chk("br_src_ready", 32'(src.tready), 0);
        tick;
        branch = 1'b0;
        #1;
        chk("br_killed", 32'(snk.tvalid), 0);
        chk("br_src_ready_after", 32'(src.tready), 1);
        tick;
        src.tvalid = 1'b0;
        #1;
        chk("sw_valid", 32'(snk.tvalid), 1);
        chk("sw_pc", o.pc, 32'h14);
        chk("sw_store", 32'(o.store), 1);
        chk("sw_imm", o.imm, 32'd8);
        chk("sw_rs2", o.rs2_val, 32'h5678);

        // illegal opcode
        send(32'h18, 32'hFFFFFFFF);
        tick;
        src.tvalid = 1'b0;
        #1;
        chk("ill_valid", 32'(snk.tvalid), 1);
        chk("ill_flags", 32'({o.load, o.store, o.branch, o.jump, o.illegal}), 32'b00001);

        // reset while a beat is held
        snk.tready = 1'b0;
        tick;
        rstn = 1'b0;
        tick;
        chk("mrst_valid", 32'(snk.tvalid), 0);
        chk("mrst_src_ready", 32'(src.tready), 0);
        rstn = 1'b1; snk.tready = 1'b1;
        tick;
        chk("mrst_no_stale", 32'(snk.tvalid), 0);

        // format/immediate table
        for (int i = 0; i < 5; i++) begin
            send(32'h100 + 32'(i) * 4, t_ir[i]);
            tick;
            src.tvalid = 1'b0;
            #1;
            chk("tbl_valid", 32'(snk.tvalid), 1);
            chk("tbl_imm", o.imm, t_imm[i]);
            chk("tbl_flags", 32'({o.load, o.store, o.branch, o.jump, o.illegal}), 32'(t_fl[i]));
            chk("tbl_alu", 32'(o.alu_op), 32'(t_alu[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
